// File: rtl/apb_slave.sv
// APB register block for an SPI controller: control, baud and status registers,
// transmit/receive data buffers, transmit hand-off to the shifter and interrupt generation.
module apb_slave (
    input  logic       PCLK,
    input  logic       PRESET_n,
    input  logic       PWRITE_i,
    input  logic       PSEL_i,
    input  logic       PENABLE_i,
    input  logic [2:0] PAADR_i,
    input  logic [7:0] PWDATA_i,
    input  logic       ss_i,
    input  logic       recieve_data_i,
    input  logic       tip_i,
    input  logic       recieve_data_o,
    input  logic [7:0] miso_data_i,
    output logic [7:0] PRDATA_o,
    output logic       PREADY_o,
    output logic       PSLVRR_o,
    output logic       mstr_o,
    output logic       cpol_o,
    output logic       cpha_o,
    output logic       lsbfe_o,
    output logic       spiswai,
    output logic [2:0] sppr_o,
    output logic [2:0] spr_o,
    output logic       spi_interrupt_request_o,
    output logic       send_data_o,
    output logic [7:0] mosi_data_o,
    output logic       spi_mode_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ENABLE = 2'd2
    } state_t;

    state_t     state_r, next_s;
    logic [7:0] cr1_r, cr2_r, br_r, txbuf_r, rxbuf_r, mosi_r, rdata_s, sr_s;
    logic       spif_r, sptef_r, send_r;
    logic       commit_s, wr_s, rd_s, bad_addr_s, err_s, dr_wr_s, dr_rd_s;
    logic       handoff_s, modf_s, unused_s;

    assign unused_s = recieve_data_o;

    // APB state register
    always_ff @(posedge PCLK) begin
        if (PRESET_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // APB next-state decode
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (PSEL_i) next_s = SETUP;
                else        next_s = IDLE;
            end
            SETUP:   next_s = ENABLE;
            ENABLE: begin
                if (PSEL_i && !PENABLE_i) next_s = SETUP;
                else                      next_s = IDLE;
            end
            default: next_s = IDLE;
        endcase
    end

    assign commit_s   = (state_r == ENABLE) && PSEL_i && PENABLE_i;
    assign wr_s       = commit_s && PWRITE_i;
    assign rd_s       = commit_s && !PWRITE_i;
    assign bad_addr_s = (PAADR_i == 3'd4) || (PAADR_i == 3'd6) || (PAADR_i == 3'd7);
    assign err_s      = commit_s && (bad_addr_s || (PWRITE_i && (PAADR_i == 3'd3)));
    assign dr_wr_s    = wr_s && (PAADR_i == 3'd5);
    assign dr_rd_s    = rd_s && (PAADR_i == 3'd5);
    // A DR write in the same cycle defers the hand-off so the fresh byte is the one sent
    assign handoff_s  = !sptef_r && cr1_r[6] && !tip_i && !dr_wr_s;
    assign modf_s     = cr1_r[4] & cr2_r[4] & ~cr1_r[1] & ~ss_i;
    assign sr_s       = {spif_r, 1'b0, sptef_r, modf_s, 4'b0000};

    // Configuration registers and transmit buffer
    always_ff @(posedge PCLK) begin
        if (PRESET_n) begin
            cr1_r   <= 8'h04;
            cr2_r   <= 8'h00;
            br_r    <= 8'h00;
            txbuf_r <= 8'h00;
        end else if (wr_s && !err_s) begin
            case (PAADR_i)
                3'd0:    cr1_r   <= PWDATA_i;
                3'd1:    cr2_r   <= PWDATA_i & 8'h1B;
                3'd2:    br_r    <= PWDATA_i & 8'h77;
                3'd5:    txbuf_r <= PWDATA_i;
                default: cr1_r   <= cr1_r;
            endcase
        end else begin
            cr1_r <= cr1_r;
        end
    end

    // Transmit hand-off, receive capture and status flags
    always_ff @(posedge PCLK) begin
        if (PRESET_n) begin
            sptef_r <= 1'b1;
            spif_r  <= 1'b0;
            send_r  <= 1'b0;
            mosi_r  <= 8'h00;
            rxbuf_r <= 8'h00;
        end else begin
            send_r <= handoff_s;
            if (handoff_s) mosi_r <= txbuf_r;
            if (dr_wr_s)        sptef_r <= 1'b0;
            else if (handoff_s) sptef_r <= 1'b1;
            if (recieve_data_i) begin
                rxbuf_r <= miso_data_i;
                spif_r  <= 1'b1;
            end else if (dr_rd_s) begin
                spif_r  <= 1'b0;
            end
        end
    end

    // Read data mux, driven only during a committed read
    always_comb begin
        rdata_s = 8'h00;
        if (rd_s) begin
            case (PAADR_i)
                3'd0:    rdata_s = cr1_r;
                3'd1:    rdata_s = cr2_r;
                3'd2:    rdata_s = br_r;
                3'd3:    rdata_s = sr_s;
                3'd5:    rdata_s = rxbuf_r;
                default: rdata_s = 8'h00;
            endcase
        end else begin
            rdata_s = 8'h00;
        end
    end

    assign PRDATA_o    = rdata_s;
    assign PREADY_o    = (state_r == ENABLE);
    assign PSLVRR_o    = err_s;
    assign mstr_o      = cr1_r[4];
    assign cpol_o      = cr1_r[3];
    assign cpha_o      = cr1_r[2];
    assign lsbfe_o     = cr1_r[0];
    assign spiswai     = cr2_r[1];
    assign sppr_o      = br_r[6:4];
    assign spr_o       = br_r[2:0];
    assign spi_mode_o  = cr1_r[6];
    assign send_data_o = send_r;
    assign mosi_data_o = mosi_r;
    assign spi_interrupt_request_o = (cr1_r[7] & (spif_r | modf_s)) | (cr1_r[5] & sptef_r);

endmodule

// File: tb/tb_apb_slave.sv
// Bench for apb_slave: directed and random APB traffic against a register-level
// reference model; a monitor compares read responses from a queue and outputs every cycle.
module tb_apb_slave;

    logic       PCLK = 1'b0;
    logic       PRESET_n, PWRITE_i, PSEL_i, PENABLE_i, ss_i, recieve_data_i, tip_i, recieve_data_o;
    logic [2:0] PAADR_i;
    logic [7:0] PWDATA_i, miso_data_i;
    logic [7:0] PRDATA_o, mosi_data_o;
    logic       PREADY_o, PSLVRR_o, mstr_o, cpol_o, cpha_o, lsbfe_o, spiswai;
    logic [2:0] sppr_o, spr_o;
    logic       spi_interrupt_request_o, send_data_o, spi_mode_o;

    always #5 PCLK = ~PCLK;

    apb_slave dut (
        .PCLK(PCLK), .PRESET_n(PRESET_n), .PWRITE_i(PWRITE_i), .PSEL_i(PSEL_i),
        .PENABLE_i(PENABLE_i), .PAADR_i(PAADR_i), .PWDATA_i(PWDATA_i), .ss_i(ss_i),
        .recieve_data_i(recieve_data_i), .tip_i(tip_i), .recieve_data_o(recieve_data_o),
        .miso_data_i(miso_data_i), .PRDATA_o(PRDATA_o), .PREADY_o(PREADY_o),
        .PSLVRR_o(PSLVRR_o), .mstr_o(mstr_o), .cpol_o(cpol_o), .cpha_o(cpha_o),
        .lsbfe_o(lsbfe_o), .spiswai(spiswai), .sppr_o(sppr_o), .spr_o(spr_o),
        .spi_interrupt_request_o(spi_interrupt_request_o), .send_data_o(send_data_o),
        .mosi_data_o(mosi_data_o), .spi_mode_o(spi_mode_o)
    );

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;
    bit exp_commit = 1'b0;
    bit rand_side = 1'b0;

    // reference model state
    logic [7:0] m_cr1, m_cr2, m_br, m_tx, m_rx, m_mosi;
    bit m_spif, m_sptef, m_send, dr_wr, go;

    typedef struct packed { logic [7:0] d; logic e; } rsp_t;
    rsp_t rsp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_modf();
        return m_cr1[4] & m_cr2[4] & ~m_cr1[1] & ~ss_i;
    endfunction

    function automatic logic [7:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return m_cr1;
            3'd1:    return m_cr2;
            3'd2:    return m_br;
            3'd3:    return {m_spif, 1'b0, m_sptef, m_modf(), 4'b0000};
            3'd5:    return m_rx;
            default: return 8'h00;
        endcase
    endfunction

    // model: register updates at each rising edge from the inputs the bench drove
    initial forever begin
        @(posedge PCLK);
        if (PRESET_n) begin
            m_cr1 = 8'h04; m_cr2 = 8'h00; m_br = 8'h00; m_tx = 8'h00; m_rx = 8'h00;
            m_mosi = 8'h00; m_spif = 1'b0; m_sptef = 1'b1; m_send = 1'b0;
        end else begin
            dr_wr = exp_commit && PWRITE_i && (PAADR_i == 3'd5);
            go = !m_sptef && m_cr1[6] && !tip_i && !dr_wr;
            m_send = go;
            if (go) begin
                m_mosi = m_tx;
                m_sptef = 1'b1;
            end
            if (exp_commit && PWRITE_i) begin
                case (PAADR_i)
                    3'd0: m_cr1 = PWDATA_i;
                    3'd1: m_cr2 = PWDATA_i & 8'h1B;
                    3'd2: m_br  = PWDATA_i & 8'h77;
                    3'd5: begin m_tx = PWDATA_i; m_sptef = 1'b0; end
                    default: ;
                endcase
            end
            if (recieve_data_i) begin
                m_rx = miso_data_i;
                m_spif = 1'b1;
            end else if (exp_commit && !PWRITE_i && (PAADR_i == 3'd5)) begin
                m_spif = 1'b0;
            end
        end
    end

    // monitor: pops expected responses on completed accesses, checks outputs each cycle
    initial forever begin
        rsp_t r;
        @(negedge PCLK);
        if (started) begin
            chk("pready", PREADY_o, exp_commit);
            if (PREADY_o && PSEL_i && PENABLE_i) begin
                if (rsp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_access: got a response, required none at %0t", $time);
                end else begin
                    r = rsp_q.pop_front();
                    chk("prdata", PRDATA_o, r.d);
                    chk("pslverr", PSLVRR_o, r.e);
                end
            end else begin
                chk("prdata_idle", PRDATA_o, 8'h00);
                chk("pslverr_idle", PSLVRR_o, 1'b0);
            end
            chk("send", send_data_o, m_send);
            chk("mosi", mosi_data_o, m_mosi);
            chk("cfg", {mstr_o, cpol_o, cpha_o, lsbfe_o, spiswai, sppr_o, spr_o, spi_mode_o},
                {m_cr1[4], m_cr1[3], m_cr1[2], m_cr1[0], m_cr2[1], m_br[6:4], m_br[2:0], m_cr1[6]});
            chk("irq", spi_interrupt_request_o,
                (m_cr1[7] & (m_spif | m_modf())) | (m_cr1[5] & m_sptef));
        end
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
        if (rand_side) begin
            tip_i          = ($urandom_range(0, 3) == 0);
            recieve_data_i = ($urandom_range(0, 7) == 0);
            miso_data_i    = 8'($urandom);
            ss_i           = 1'($urandom_range(0, 1));
        end else begin
            recieve_data_i = 1'b0;
        end
    endtask

    task automatic apb(input bit w, input logic [2:0] a, input logic [7:0] d);
        rsp_t r;
        tick();
        PSEL_i = 1'b1; PENABLE_i = 1'b0; PWRITE_i = w; PAADR_i = a; PWDATA_i = d;
        tick();
        PENABLE_i = 1'b1;
        tick();
        exp_commit = 1'b1;
        r.d = w ? 8'h00 : m_read(a);
        r.e = (a == 3'd4) || (a == 3'd6) || (a == 3'd7) || (w && (a == 3'd3));
        rsp_q.push_back(r);
        tick();
        exp_commit = 1'b0; PSEL_i = 1'b0; PENABLE_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESET_n = 1'b1; PWRITE_i = 1'b0; PSEL_i = 1'b0; PENABLE_i = 1'b0; PAADR_i = 3'd0;
        PWDATA_i = 8'h00; ss_i = 1'b1; recieve_data_i = 1'b0; tip_i = 1'b0;
        recieve_data_o = 1'b0; miso_data_i = 8'h00;
        tick();
        started = 1'b1;
        tick();
        PRESET_n = 1'b0;

        // reset values
        apb(1'b0, 3'd0, 8'h00);
        apb(1'b0, 3'd3, 8'h00);
        apb(1'b0, 3'd2, 8'h00);
        // write masks
        apb(1'b1, 3'd1, 8'hFF);
        apb(1'b1, 3'd2, 8'hFF);
        apb(1'b0, 3'd1, 8'h00);
        apb(1'b0, 3'd2, 8'h00);
        // transmit hand-off
        apb(1'b1, 3'd0, 8'h40);
        apb(1'b1, 3'd5, 8'hA5);
        tick(); tick();
        tip_i = 1'b1;
        apb(1'b1, 3'd5, 8'h5A);
        apb(1'b0, 3'd3, 8'h00);
        tip_i = 1'b0;
        tick(); tick();
        apb(1'b0, 3'd3, 8'h00);
        // receive and interrupt
        apb(1'b1, 3'd0, 8'hC0);
        tick();
        recieve_data_i = 1'b1; miso_data_i = 8'h3C;
        tick();
        apb(1'b0, 3'd3, 8'h00);
        apb(1'b0, 3'd5, 8'h00);
        apb(1'b0, 3'd3, 8'h00);
        // mode fault
        ss_i = 1'b0;
        apb(1'b1, 3'd0, 8'h12);
        apb(1'b1, 3'd1, 8'h10);
        apb(1'b0, 3'd3, 8'h00);
        apb(1'b1, 3'd0, 8'h10);
        apb(1'b0, 3'd3, 8'h00);
        ss_i = 1'b1;
        // error responses
        apb(1'b0, 3'd6, 8'h00);
        apb(1'b1, 3'd6, 8'h55);
        apb(1'b1, 3'd3, 8'hFF);
        apb(1'b0, 3'd3, 8'h00);
        apb(1'b0, 3'd4, 8'h00);
        apb(1'b0, 3'd7, 8'h00);
        // reset in the middle of a transfer
        apb(1'b1, 3'd2, 8'h35);
        tick();
        PSEL_i = 1'b1; PENABLE_i = 1'b0; PWRITE_i = 1'b1; PAADR_i = 3'd0; PWDATA_i = 8'hFF;
        tick();
        PRESET_n = 1'b1; PSEL_i = 1'b0;
        tick();
        PRESET_n = 1'b0;
        apb(1'b0, 3'd0, 8'h00);
        apb(1'b0, 3'd2, 8'h00);
        apb(1'b0, 3'd3, 8'h00);
        // random traffic
        rand_side = 1'b1;
        repeat (300) apb(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom));
        rand_side = 1'b0;
        tip_i = 1'b0;
        tick(); tick(); tick();
        chk("responses_left", rsp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
